// File: rtl/pcie_fetch_pkg.sv
// Shared types and constants for the PCIe message fetch controller.
package pcie_fetch_pkg;

  localparam int unsigned HDR_W          = 128;
  localparam int unsigned LEN_W          = 12;
  localparam int unsigned DATA_W         = 256;
  localparam int unsigned SRAM_DEPTH_MAX = 1024;
  // Pointer storage width; any power-of-2 SRAM_DEPTH up to SRAM_DEPTH_MAX fits.
  localparam int unsigned ADDR_W         = $clog2(SRAM_DEPTH_MAX);

  localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
  } desc_t;

  localparam int unsigned DESC_W = $bits(desc_t);

endpackage

// File: rtl/pcie_msg_fetch_ctrl_if.sv
// Message-in, AXI AR/R and framed stream-out signals of the fetch controller.
// Optional stats outputs exist only when PCIE_FETCH_STATS_EN is defined.
interface pcie_msg_fetch_ctrl_if;
  logic                               msg_valid;
  logic [pcie_fetch_pkg::HDR_W-1:0]   msg_header;
  logic [pcie_fetch_pkg::LEN_W-1:0]   msg_length;
  logic                               axi_arvalid;
  logic [31:0]                        axi_araddr;
  logic [7:0]                         axi_arlen;
  logic [2:0]                         axi_arsize;
  logic [1:0]                         axi_arburst;
  logic                               axi_arready;
  logic                               axi_rvalid;
  logic [pcie_fetch_pkg::DATA_W-1:0]  axi_rdata;
  logic [1:0]                         axi_rresp;
  logic                               axi_rlast;
  logic                               axi_rready;
  logic                               out_valid;
  logic [pcie_fetch_pkg::DATA_W-1:0]  out_data;
  logic                               out_sof;
  logic                               out_eof;
  logic [pcie_fetch_pkg::HDR_W-1:0]   out_header;
  logic                               out_ready;
  logic                               desc_full;
  logic                               rd_err;
`ifdef PCIE_FETCH_STATS_EN
  logic [15:0]                        stat_fetched;
  logic [15:0]                        stat_dropped;
  logic [15:0]                        stat_rerr;
`endif

  // Controller side
  modport master (
    input  msg_valid, msg_header, msg_length,
    output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
    input  axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    output axi_rready,
    output out_valid, out_data, out_sof, out_eof, out_header,
    input  out_ready,
    output desc_full, rd_err
`ifdef PCIE_FETCH_STATS_EN
    , output stat_fetched, stat_dropped, stat_rerr
`endif
  );

  // Environment side
  modport slave (
    output msg_valid, msg_header, msg_length,
    input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
    output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_rready,
    input  out_valid, out_data, out_sof, out_eof, out_header,
    output out_ready,
    input  desc_full, rd_err
`ifdef PCIE_FETCH_STATS_EN
    , input stat_fetched, stat_dropped, stat_rerr
`endif
  );
endinterface

// File: rtl/pcie_msg_fetch_ctrl_desc_fifo.sv
// Descriptor FIFO: synchronous, power-of-2 depth, head visible without a pop.
module pcie_desc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_idx];

  // Storage array, written on push only
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

  // Pointers and occupancy; caller guarantees push is only raised when there is room
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pcie_msg_fetch_ctrl.sv
// Queues completed messages, reads their payload back over AXI in bursts that
// never cross the SRAM wrap, and forwards it as a framed stream.
// Optional feature macro: PCIE_FETCH_STATS_EN (saturating activity counters).
module pcie_msg_fetch_ctrl
  import pcie_fetch_pkg::*;
#(
  parameter int unsigned SRAM_DEPTH = 1024,
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned MAX_BURST  = 16,
  parameter logic [31:0] AXI_BASE   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  pcie_msg_fetch_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] PTR_MASK = ADDR_W'(SRAM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] cur_ptr_q, cur_ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              first_q, first_d;
  logic              rd_err_q;
  desc_t             head, push_desc;
  logic              push, pop, full, empty;
  logic [12:0]       room, blen_w;
  logic [8:0]        blen;
  logic              in_addr, in_data, beat, eof_c;

  assign in_addr   = (state_q == ST_ADDR);
  assign in_data   = (state_q == ST_DATA);
  assign beat      = in_data && bus.axi_rvalid && bus.out_ready;
  assign eof_c     = bus.axi_rlast && (remain_q == 12'(blen));
  assign pop       = beat && eof_c;
  assign push      = bus.msg_valid && (bus.msg_length != '0) && (!full || pop);
  assign push_desc = '{hdr: bus.msg_header, base: wr_ptr_q, len: bus.msg_length};
  assign room      = 13'(SRAM_DEPTH) - 13'(cur_ptr_q);

  pcie_desc_fifo #(.WIDTH(DESC_W), .DEPTH(DESC_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_desc),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Burst length: remaining beats, clipped to MAX_BURST and to the SRAM wrap
  always_comb begin
    blen_w = {1'b0, remain_q};
    if (blen_w > 13'(MAX_BURST)) blen_w = 13'(MAX_BURST);
    if (blen_w > room)           blen_w = room;
    blen = 9'(blen_w);
  end

  // Running SRAM write pointer; advances even for dropped messages
  always_ff @(posedge clk) begin
    if (rst)                wr_ptr_q <= '0;
    else if (bus.msg_valid) wr_ptr_q <= (wr_ptr_q + ADDR_W'(bus.msg_length)) & PTR_MASK;
  end

  // FSM and fetch-progress registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_ptr_q <= '0;
      remain_q  <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ptr_q <= cur_ptr_d;
      remain_q  <= remain_d;
      first_q   <= first_d;
    end
  end

  // Next-state: load descriptor, issue AR, stream R, then re-arm or retire
  always_comb begin
    state_d   = state_q;
    cur_ptr_d = cur_ptr_q;
    remain_d  = remain_q;
    first_d   = first_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          cur_ptr_d = head.base;
          remain_d  = head.len;
          first_d   = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.axi_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat) begin
          first_d = 1'b0;
          if (bus.axi_rlast) begin
            cur_ptr_d = (cur_ptr_q + ADDR_W'(blen)) & PTR_MASK;
            remain_d  = remain_q - 12'(blen);
            state_d   = (remain_q == 12'(blen)) ? ST_IDLE : ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky read-error flag
  always_ff @(posedge clk) begin
    if (rst)                                             rd_err_q <= 1'b0;
    else if (beat && (bus.axi_rresp != AXI_RESP_OKAY))   rd_err_q <= 1'b1;
  end

  // AR request from registered state; R stream passes straight through in DATA
  always_comb begin
    bus.axi_arvalid = in_addr;
    bus.axi_araddr  = in_addr ? (AXI_BASE + 32'({cur_ptr_q, 5'b0})) : '0;
    bus.axi_arlen   = in_addr ? 8'(blen - 9'd1) : '0;
    bus.axi_arsize  = in_addr ? AXI_SIZE_32B : '0;
    bus.axi_arburst = in_addr ? AXI_BURST_INCR : '0;
    bus.axi_rready  = in_data && bus.out_ready;
    bus.out_valid   = in_data && bus.axi_rvalid;
    bus.out_data    = in_data ? bus.axi_rdata : '0;
    bus.out_sof     = bus.out_valid && first_q;
    bus.out_eof     = bus.out_valid && eof_c;
    bus.out_header  = in_data ? head.hdr : '0;
    bus.desc_full   = full;
    bus.rd_err      = rd_err_q;
  end

`ifdef PCIE_FETCH_STATS_EN
  logic [15:0] fetched_q, dropped_q, rerr_q;

  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
      rerr_q    <= '0;
    end else begin
      if (pop && (fetched_q != 16'hFFFF)) fetched_q <= fetched_q + 1'b1;
      if (bus.msg_valid && !push && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 1'b1;
      if (beat && (bus.axi_rresp != AXI_RESP_OKAY) && (rerr_q != 16'hFFFF)) rerr_q <= rerr_q + 1'b1;
    end
  end

  assign bus.stat_fetched = fetched_q;
  assign bus.stat_dropped = dropped_q;
  assign bus.stat_rerr    = rerr_q;
`endif

endmodule

// File: tb/tb_pcie_msg_fetch_ctrl.sv
// Randomised and directed bench for pcie_msg_fetch_ctrl against a
// burst-level behavioural model (descriptor queue + per-message progress).
module tb_pcie_msg_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcie_msg_fetch_ctrl_if bus();

  pcie_msg_fetch_ctrl #(
    .SRAM_DEPTH(1024), .DESC_DEPTH(4), .MAX_BURST(16), .AXI_BASE(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [127:0] hdr;
    int           base;
    int           len;
  } mdesc_t;

  mdesc_t q[$];
  int  wr_ptr_m, front_off, beat, exp_blen;
  bit  burst_active, rd_err_m;
  int  fetched_m, dropped_m, rerr_m;
  int  checks, failures;
  int  ar_addr_log[$];
  int  ar_len_log[$];
  int  sof_seen, eof_seen, beats_out;
  int  ar_mode, or_mode, rv_mode, err_beat;
  bit  or_tog, rv_hold;
  logic [255:0] rdata_cur;
  logic [1:0]   rresp_cur;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand_hdr();
    logic [127:0] h;
    for (int i = 0; i < 4; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  // Next burst of the front message from its progress
  function automatic void exp_burst(output int cur, output int blen);
    int remain;
    remain = q[0].len - front_off;
    cur    = (q[0].base + front_off) % 1024;
    blen   = remain;
    if (blen > 16) blen = 16;
    if (blen > 1024 - cur) blen = 1024 - cur;
  endfunction

  task automatic clear_logs();
    ar_addr_log.delete();
    ar_len_log.delete();
    sof_seen = 0; eof_seen = 0; beats_out = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model
  task automatic step(input bit mv, input int len, input logic [127:0] hdr);
    int cur, blen;
    bit pop_m, ar_hs;
    mdesc_t d;
    @(negedge clk);
    bus.msg_valid   = mv;
    bus.msg_length  = 12'(len);
    bus.msg_header  = hdr;
    bus.axi_arready = (ar_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ar_mode);
    case (or_mode)
      1: bus.out_ready = 1'b1;
      2: begin or_tog = ~or_tog; bus.out_ready = or_tog; end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    if (!burst_active) rv_hold = 1'b0;
    else if (!rv_hold && (rv_mode == 1 || $urandom_range(0, 2) != 0)) begin
      rv_hold = 1'b1;
      for (int i = 0; i < 8; i++) rdata_cur[i*32 +: 32] = $urandom;
      if (beat == err_beat) rresp_cur = 2'b10;
      else if (err_beat == -1 && $urandom_range(0, 19) == 0) rresp_cur = 2'($urandom_range(1, 3));
      else rresp_cur = 2'b00;
    end
    bus.axi_rvalid = rv_hold;
    bus.axi_rdata  = rv_hold ? rdata_cur : '0;
    bus.axi_rresp  = rv_hold ? rresp_cur : 2'b00;
    bus.axi_rlast  = rv_hold && (beat == exp_blen - 1);
    #1;
    chk("desc_full", bus.desc_full, q.size() == 4);
    chk("rd_err", bus.rd_err, rd_err_m);
`ifdef PCIE_FETCH_STATS_EN
    chk("stat_fetched", bus.stat_fetched, 16'(fetched_m));
    chk("stat_dropped", bus.stat_dropped, 16'(dropped_m));
    chk("stat_rerr", bus.stat_rerr, 16'(rerr_m));
`endif
    ar_hs = 1'b0;
    blen  = 0;
    if (bus.axi_arvalid) begin
      if (burst_active || q.size() == 0) chk("ar_spurious", bus.axi_arvalid, 1'b0);
      else begin
        exp_burst(cur, blen);
        chk("araddr", bus.axi_araddr, 32'(cur * 32));
        chk("arlen", bus.axi_arlen, 8'(blen - 1));
        chk("arsize", bus.axi_arsize, 3'd5);
        chk("arburst", bus.axi_arburst, 2'b01);
        if (bus.axi_arready) begin
          ar_hs = 1'b1;
          ar_addr_log.push_back(int'(bus.axi_araddr));
          ar_len_log.push_back(int'(bus.axi_arlen));
        end
      end
    end
    chk("rready", bus.axi_rready, burst_active && bus.out_ready);
    chk("out_valid", bus.out_valid, burst_active && rv_hold);
    if (burst_active && rv_hold) begin
      chk("out_data", bus.out_data, rdata_cur);
      chk("out_header", bus.out_header, q[0].hdr);
      chk("out_sof", bus.out_sof, front_off == 0 && beat == 0);
      chk("out_eof", bus.out_eof, beat == exp_blen - 1 && q[0].len - front_off == exp_blen);
      if (bus.out_ready && bus.out_sof) sof_seen++;
      if (bus.out_ready && bus.out_eof) eof_seen++;
    end
    pop_m = 1'b0;
    if (burst_active && rv_hold && bus.out_ready) begin
      if (rresp_cur != 2'b00) begin rd_err_m = 1'b1; rerr_m++; end
      rv_hold = 1'b0;
      beats_out++;
      if (beat == exp_blen - 1) begin
        front_off += exp_blen;
        burst_active = 1'b0;
        beat = 0;
        if (front_off == q[0].len) begin pop_m = 1'b1; fetched_m++; end
      end else beat++;
    end
    if (ar_hs) begin burst_active = 1'b1; exp_blen = blen; beat = 0; end
    if (pop_m) begin void'(q.pop_front()); front_off = 0; end
    if (mv) begin
      if (len > 0 && q.size() < 4) begin
        d.hdr = hdr; d.base = wr_ptr_m; d.len = len;
        q.push_back(d);
      end else dropped_m++;
      wr_ptr_m = (wr_ptr_m + len) % 1024;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.msg_valid = 1'b0; bus.msg_length = '0; bus.msg_header = '0;
    bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0;
    bus.axi_rresp = 2'b00; bus.axi_rlast = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", bus.axi_arvalid, 1'b0);
    chk("rst_araddr", bus.axi_araddr, 32'h0);
    chk("rst_arlen", bus.axi_arlen, 8'h0);
    chk("rst_rready", bus.axi_rready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_desc_full", bus.desc_full, 1'b0);
    chk("rst_rd_err", bus.rd_err, 1'b0);
    q.delete();
    wr_ptr_m = 0; front_off = 0; beat = 0; exp_blen = 0;
    burst_active = 1'b0; rd_err_m = 1'b0; rv_hold = 1'b0;
    fetched_m = 0; dropped_m = 0; rerr_m = 0;
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || burst_active) && n < 4000) begin
      step(1'b0, 0, '0);
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    checks = 0; failures = 0; or_tog = 1'b0;
    ar_mode = 1; or_mode = 1; rv_mode = 1; err_beat = -2;
    do_reset();

    // Single short message
    step(1'b1, 3, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    drain();
    chk("t1_ar_count", 32'(ar_addr_log.size()), 32'(1));
    chk("t1_araddr", 32'(ar_addr_log[0]), 32'h0);
    chk("t1_arlen", 32'(ar_len_log[0]), 32'd2);
    chk("t1_beats", 32'(beats_out), 32'd3);
    chk("t1_sof", 32'(sof_seen), 32'd1);
    chk("t1_eof", 32'(eof_seen), 32'd1);
    chk("t1_wr_ptr", 32'(wr_ptr_m), 32'd3);

    // Split into MAX_BURST pieces
    do_reset();
    step(1'b1, 40, rand_hdr());
    drain();
    chk("t2_ar_count", 32'(ar_addr_log.size()), 32'(3));
    chk("t2_addr0", 32'(ar_addr_log[0]), 32'h000);
    chk("t2_addr1", 32'(ar_addr_log[1]), 32'h200);
    chk("t2_addr2", 32'(ar_addr_log[2]), 32'h400);
    chk("t2_len0", 32'(ar_len_log[0]), 32'd15);
    chk("t2_len2", 32'(ar_len_log[2]), 32'd7);
    chk("t2_sof", 32'(sof_seen), 32'd1);
    chk("t2_eof", 32'(eof_seen), 32'd1);

    // Wrap: park wr_ptr at 1020 using queued and dropped messages
    do_reset();
    ar_mode = 0;
    repeat (4) step(1'b1, 1, rand_hdr());
    step(1'b1, 1016, rand_hdr());
    ar_mode = 1;
    drain();
    clear_logs();
    step(1'b1, 8, rand_hdr());
    drain();
    chk("t3_ar_count", 32'(ar_addr_log.size()), 32'(2));
    chk("t3_addr0", 32'(ar_addr_log[0]), 32'h7F80);
    chk("t3_len0", 32'(ar_len_log[0]), 32'd3);
    chk("t3_addr1", 32'(ar_addr_log[1]), 32'h0);
    chk("t3_len1", 32'(ar_len_log[1]), 32'd3);
    chk("t3_wr_ptr", 32'(wr_ptr_m), 32'd4);

    // Toggling backpressure
    do_reset();
    or_mode = 2;
    step(1'b1, 20, rand_hdr());
    drain();
    chk("t4_beats", 32'(beats_out), 32'd20);
    or_mode = 1;

    // Overflow with AR stalled
    do_reset();
    ar_mode = 0;
    repeat (6) step(1'b1, 2, rand_hdr());
    step(1'b0, 0, '0);
    chk("t5_full", bus.desc_full, 1'b1);
    chk("t5_dropped", 32'(dropped_m), 32'd2);
    chk("t5_wr_ptr", 32'(wr_ptr_m), 32'd12);
`ifdef PCIE_FETCH_STATS_EN
    chk("t5_stat_dropped", bus.stat_dropped, 16'd2);
`endif
    ar_mode = 1;
    clear_logs();
    drain();
    chk("t5_ar_count", 32'(ar_addr_log.size()), 32'(4));
    for (int i = 0; i < 4 && i < ar_addr_log.size(); i++)
      chk($sformatf("t5_addr%0d", i), 32'(ar_addr_log[i]), 32'(i * 64));

    // Error response on the second beat
    do_reset();
    err_beat = 1;
    step(1'b1, 2, rand_hdr());
    drain();
    repeat (5) step(1'b0, 0, '0);
    chk("t6_rd_err", bus.rd_err, 1'b1);
    chk("t6_beats", 32'(beats_out), 32'd2);
    err_beat = -2;

    // Randomised traffic, then a reset in the middle of a burst
    do_reset();
    ar_mode = 2; or_mode = 3; rv_mode = 2; err_beat = -1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0)
        step(1'b1, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40)), rand_hdr());
      else
        step(1'b0, 0, '0);
    end
    drain();
    step(1'b1, 30, rand_hdr());
    for (int i = 0; i < 200 && !burst_active; i++) step(1'b0, 0, '0);
    chk("t7_in_burst", burst_active, 1'b1);
    step(1'b0, 0, '0);
    do_reset();
    ar_mode = 1; or_mode = 1; rv_mode = 1; err_beat = -2;
    repeat (5) step(1'b0, 0, '0);
    step(1'b1, 5, rand_hdr());
    drain();
    chk("t7_ar_after_rst", 32'(ar_addr_log.size() > 0 ? ar_addr_log[0] : -1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
